qick_vec_pulser: RTL and testbench

//  Timed pulse scheduler for a 16-bit trigger vector. Accepts commands (bit mask, start delay, pulse length) over a

---
 rtl/qick_vec_pulser_pkg.sv | 15 +
 rtl/qick_pulse_cnt.sv | 41 ++++
 rtl/qick_vec_pulser.sv | 139 +++++++++++++
 tb/tb_qick_vec_pulser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qick_vec_pulser_pkg.sv
// Shared definitions for the vector pulse scheduler.
//   state_t        : command FSM states (idle / counting down start delay)
//   *_DW_DEF       : default vector, pulse-length and delay widths
package qick_vec_pulser_pkg;

    localparam int unsigned OUT_DW_DEF = 16;
    localparam int unsigned LEN_DW_DEF = 16;
    localparam int unsigned DLY_DW_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DLY  = 1'b1
    } state_t;

endpackage

// File: rtl/qick_pulse_cnt.sv
// One trigger channel: a down-counter plus a registered output bit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : fire this channel (reloads len_i, also while already running)
//   len_i         : pulse length in cycles, non-zero whenever load_i is set
//   clr_i         : synchronous abort, wins over load_i
//   dout_o        : pulse output, straight from a flop
//   active_o      : counter non-zero (channel currently pulsing)
module qick_pulse_cnt #(
    parameter int unsigned LEN_DW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LEN_DW-1:0] len_i,
    input  logic              clr_i,
    output logic              dout_o,
    output logic              active_o
);

    logic [LEN_DW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            dout_o <= 1'b0;
        end else if (clr_i) begin
            cnt    <= '0;
            dout_o <= 1'b0;
        end else if (load_i) begin
            cnt    <= len_i;
            dout_o <= 1'b1;
        end else if (cnt != '0) begin
            // Output drops on the same edge the counter reaches zero.
            cnt    <= cnt - 1'b1;
            dout_o <= (cnt != LEN_DW'(1));
        end
    end

    assign active_o = (cnt != '0);

endmodule

// File: rtl/qick_vec_pulser.sv
// Timed pulse scheduler for a trigger vector. A command (mask, delay, length)
// is accepted over valid/ready; after the delay each masked bit is driven
// high for exactly 'length' cycles. Bits run independently.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   cmd_valid_i     : command valid
//   cmd_ready_o     : command ready (idle, not clearing, not in reset)
//   cmd_mask_i      : bits to pulse
//   cmd_dly_i       : start delay in cycles
//   cmd_len_i       : pulse length in cycles
//   clr_i           : synchronous abort of everything, blocks acceptance
//   dout_o          : trigger vector (registered)
//   busy_o          : delay pending or any output bit high
//   retrig_o        : sticky flag, a fire reloaded a bit that was still high
module qick_vec_pulser
    import qick_vec_pulser_pkg::*;
#(
    parameter int unsigned OUT_DW = OUT_DW_DEF,
    parameter int unsigned LEN_DW = LEN_DW_DEF,
    parameter int unsigned DLY_DW = DLY_DW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [OUT_DW-1:0] cmd_mask_i,
    input  logic [DLY_DW-1:0] cmd_dly_i,
    input  logic [LEN_DW-1:0] cmd_len_i,
    input  logic              clr_i,
    output logic [OUT_DW-1:0] dout_o,
    output logic              busy_o,
    output logic              retrig_o
);

    state_t            state, state_nx;
    logic [DLY_DW-1:0] dly_cnt, dly_nx;
    logic [OUT_DW-1:0] mask_q;
    logic [LEN_DW-1:0] len_q;
    logic              capture;
    logic              fire;
    logic [OUT_DW-1:0] fire_mask;
    logic [LEN_DW-1:0] fire_len;
    logic [OUT_DW-1:0] load;
    logic [OUT_DW-1:0] active;

    assign cmd_ready_o = rst_ni & (state == ST_IDLE) & ~clr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
        end else begin
            state   <= state_nx;
            dly_cnt <= dly_nx;
        end
    end

    // Delayed commands are held here; immediate ones fire straight from the inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            len_q  <= '0;
        end else if (capture) begin
            mask_q <= cmd_mask_i;
            len_q  <= cmd_len_i;
        end
    end

    always_comb begin
        state_nx  = state;
        dly_nx    = dly_cnt;
        capture   = 1'b0;
        fire      = 1'b0;
        fire_mask = mask_q;
        fire_len  = len_q;
        if (clr_i) begin
            state_nx = ST_IDLE;
            dly_nx   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        if (cmd_dly_i == '0) begin
                            fire      = 1'b1;
                            fire_mask = cmd_mask_i;
                            fire_len  = cmd_len_i;
                        end else begin
                            state_nx = ST_DLY;
                            dly_nx   = cmd_dly_i;
                            capture  = 1'b1;
                        end
                    end
                end
                ST_DLY: begin
                    // Counter holds D in the first delay cycle, so it reads 1 in cycle D.
                    if (dly_cnt <= DLY_DW'(1)) begin
                        fire     = 1'b1;
                        state_nx = ST_IDLE;
                        dly_nx   = '0;
                    end else begin
                        dly_nx = dly_cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    dly_nx   = '0;
                end
            endcase
        end
    end

    assign load = (fire && fire_len != '0) ? fire_mask : '0;

    for (genvar i = 0; i < OUT_DW; i++) begin : g_bit
        qick_pulse_cnt #(
            .LEN_DW(LEN_DW)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load_i   (load[i]),
            .len_i    (fire_len),
            .clr_i    (clr_i),
            .dout_o   (dout_o[i]),
            .active_o (active[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retrig_o <= 1'b0;
        end else if (clr_i) begin
            retrig_o <= 1'b0;
        end else if ((load & active) != '0) begin
            retrig_o <= 1'b1;
        end
    end

    assign busy_o = (state != ST_IDLE) | (dout_o != '0);

endmodule

// File: tb/tb_qick_vec_pulser.sv
// Self-checking bench for qick_vec_pulser: an absolute-time model (per-bit
// "high through cycle" marks, one pending fire time) is compared every
// cycle, plus literal checks of the directed scenarios.
module tb_qick_vec_pulser;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_mask = '0;
    logic [15:0] cmd_dly = '0;
    logic [15:0] cmd_len = '0;
    logic        clr = 1'b0;
    logic [15:0] dout;
    logic        busy;
    logic        retrig;

    qick_vec_pulser #(
        .OUT_DW(16),
        .LEN_DW(16),
        .DLY_DW(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_mask_i  (cmd_mask),
        .cmd_dly_i   (cmd_dly),
        .cmd_len_i   (cmd_len),
        .clr_i       (clr),
        .dout_o      (dout),
        .busy_o      (busy),
        .retrig_o    (retrig)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- model ----------------
    longint cyc = 0;
    longint hi_end [16];
    bit     pend = 1'b0;
    longint fire_at = 0;
    logic [15:0] p_mask = '0;
    logic [15:0] p_len = '0;
    bit     m_retrig = 1'b0;

    initial for (int i = 0; i < 16; i++) hi_end[i] = -1;

    function automatic bit m_high(int i, longint n);
        return hi_end[i] >= n;
    endfunction

    task automatic m_fire(logic [15:0] m, logic [15:0] l, longint e);
        for (int i = 0; i < 16; i++) begin
            if (m[i] && l != 0) begin
                if (m_high(i, e)) m_retrig = 1'b1;
                hi_end[i] = e + longint'(l);
            end
        end
    endtask

    always @(negedge rst_ni) begin
        for (int i = 0; i < 16; i++) hi_end[i] = -1;
        pend     = 1'b0;
        m_retrig = 1'b0;
    end

    always @(posedge clk) begin
        longint e;
        bit     rdy;
        e = cyc;
        if (rst_ni) begin
            rdy = !pend && !clr;
            if (clr) begin
                for (int i = 0; i < 16; i++) hi_end[i] = e;
                pend     = 1'b0;
                m_retrig = 1'b0;
            end else begin
                if (pend && fire_at == e) begin
                    pend = 1'b0;
                    m_fire(p_mask, p_len, e);
                end
                if (cmd_valid && rdy) begin
                    if (cmd_dly == 0) begin
                        m_fire(cmd_mask, cmd_len, e);
                    end else begin
                        pend    = 1'b1;
                        fire_at = e + longint'(cmd_dly);
                        p_mask  = cmd_mask;
                        p_len   = cmd_len;
                    end
                end
            end
        end
        cyc = e + 1;
    end

    // ---------------- compare every cycle ----------------
    always @(negedge clk) begin
        logic [15:0] exp_dout;
        logic        exp_busy, exp_ready;
        for (int i = 0; i < 16; i++) exp_dout[i] = rst_ni && m_high(i, cyc);
        exp_busy  = rst_ni && (pend || exp_dout != 0);
        exp_ready = rst_ni && !pend && !clr;
        n_chk++;
        if (dout !== exp_dout) begin
            n_fail++;
            $display("FAIL model_dout cyc=%0d got=%h exp=%h", cyc, dout, exp_dout);
        end
        n_chk++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        n_chk++;
        if (cmd_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL model_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, exp_ready);
        end
        n_chk++;
        if (retrig !== (rst_ni && m_retrig)) begin
            n_fail++;
            $display("FAIL model_retrig cyc=%0d got=%b exp=%b", cyc, retrig, m_retrig);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    task automatic nxt_neg();
        @(negedge clk);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer a command; returns at #1 after the handshake edge (cycle c1).
    task automatic send(logic [15:0] m, logic [15:0] d, logic [15:0] l);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_mask  = m;
        cmd_dly   = d;
        cmd_len   = l;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout got=0 exp=1");
        end
        sync();
        cmd_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        sync();
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) nxt_neg();
        chk("rst_dout", dout, 16'h0);
        chk("rst_ready", {15'b0, cmd_ready}, 16'h0);
        chk("rst_busy", {15'b0, busy}, 16'h0);
        chk("rst_retrig", {15'b0, retrig}, 16'h0);
        sync();
        rst_ni = 1'b1;
        sync();

        // 1: immediate fire
        send(16'h0005, 16'd0, 16'd3);
        nxt_neg(); chk("t1_c1_dout", dout, 16'h0005);
        chk("t1_c1_ready", {15'b0, cmd_ready}, 16'h1);
        nxt_neg(); nxt_neg(); chk("t1_c3_dout", dout, 16'h0005);
        nxt_neg(); chk("t1_c4_dout", dout, 16'h0000);
        chk("t1_retrig", {15'b0, retrig}, 16'h0);
        sync();

        // 2: delayed fire
        send(16'h8000, 16'd4, 16'd2);
        nxt_neg(); chk("t2_c1_ready", {15'b0, cmd_ready}, 16'h0);
        nxt_neg(); nxt_neg(); nxt_neg();
        chk("t2_c4_ready", {15'b0, cmd_ready}, 16'h0);
        chk("t2_c4_dout", dout, 16'h0000);
        nxt_neg(); chk("t2_c5_ready", {15'b0, cmd_ready}, 16'h1);
        chk("t2_c5_dout", dout, 16'h8000);
        nxt_neg(); chk("t2_c6_dout", dout, 16'h8000);
        nxt_neg(); chk("t2_c7_dout", dout, 16'h0000);
        sync();

        // 3: retrigger shortens bit0, bit1 overlaps
        send(16'h0001, 16'd0, 16'd10);
        sync(); sync(); sync();
        send(16'h0003, 16'd0, 16'd2);
        nxt_neg(); chk("t3_c5_dout", dout, 16'h0003);
        chk("t3_c5_retrig", {15'b0, retrig}, 16'h1);
        nxt_neg(); chk("t3_c6_dout", dout, 16'h0003);
        nxt_neg(); chk("t3_c7_dout", dout, 16'h0000);
        chk("t3_c7_retrig", {15'b0, retrig}, 16'h1);
        sync();
        clr_pulse();
        nxt_neg(); chk("t3_clr_retrig", {15'b0, retrig}, 16'h0);
        sync();

        // 4: zero length / zero mask
        send(16'hFFFF, 16'd3, 16'd0);
        nxt_neg(); chk("t4_c1_busy", {15'b0, busy}, 16'h1);
        nxt_neg(); nxt_neg(); chk("t4_c3_busy", {15'b0, busy}, 16'h1);
        nxt_neg(); chk("t4_c4_busy", {15'b0, busy}, 16'h0);
        chk("t4_c4_dout", dout, 16'h0000);
        sync();
        send(16'h0000, 16'd0, 16'd5);
        nxt_neg(); chk("t4b_busy", {15'b0, busy}, 16'h0);
        chk("t4b_dout", dout, 16'h0000);
        chk("t4b_retrig", {15'b0, retrig}, 16'h0);
        sync();

        // 5a: clear during delay with a command offered
        send(16'h0001, 16'd5, 16'd4);
        clr = 1'b1; cmd_valid = 1'b1;
        cmd_mask = 16'h0002; cmd_dly = 16'd0; cmd_len = 16'd3;
        nxt_neg(); chk("t5a_ready_clr", {15'b0, cmd_ready}, 16'h0);
        sync();
        clr = 1'b0; cmd_valid = 1'b0;
        nxt_neg(); chk("t5a_dout", dout, 16'h0000);
        chk("t5a_busy", {15'b0, busy}, 16'h0);
        chk("t5a_ready", {15'b0, cmd_ready}, 16'h1);
        repeat (5) nxt_neg();
        chk("t5a_nofire", dout, 16'h0000);
        sync();

        // 5b: clear mid-pulse with retrig set and a command offered
        send(16'h0004, 16'd0, 16'd6);
        send(16'h0004, 16'd0, 16'd6);
        nxt_neg(); chk("t5b_retrig_set", {15'b0, retrig}, 16'h1);
        sync();
        clr = 1'b1; cmd_valid = 1'b1;
        cmd_mask = 16'h0008; cmd_dly = 16'd0; cmd_len = 16'd3;
        sync();
        clr = 1'b0; cmd_valid = 1'b0;
        nxt_neg(); chk("t5b_dout", dout, 16'h0000);
        chk("t5b_retrig", {15'b0, retrig}, 16'h0);
        chk("t5b_busy", {15'b0, busy}, 16'h0);
        nxt_neg(); chk("t5b_not_accepted", dout, 16'h0000);
        sync();

        // 6: asynchronous reset mid-pulse
        send(16'h0005, 16'd0, 16'd3);
        #2 rst_ni = 1'b0;
        #1 chk("t6_async_dout", dout, 16'h0000);
        chk("t6_async_ready", {15'b0, cmd_ready}, 16'h0);
        sync();
        rst_ni = 1'b1;
        sync();
        send(16'h0005, 16'd0, 16'd3);
        nxt_neg(); chk("t6_c1_dout", dout, 16'h0005);
        nxt_neg(); nxt_neg(); chk("t6_c3_dout", dout, 16'h0005);
        nxt_neg(); chk("t6_c4_dout", dout, 16'h0000);
        chk("t6_retrig", {15'b0, retrig}, 16'h0);
        repeat (3) nxt_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
